// File: rtl/regfile_array.sv
// regfile_array: 32 x 64-bit register storage feeding the downstream 32:1 read muxes.
//
// Single synchronous write port. Entry ZERO_REG is hardwired to zero (XZR).
// A write to it is accepted on the port but discarded.
// Reset is synchronous and active-high. It wins over a write in the same cycle.
//
// Optional build macro: REGFILE_WRITE_BYPASS_EN
//   When it is defined, a write in flight appears on regs_out[wr_reg] in the same
//   cycle, so a same-cycle read through the downstream mux sees the new value.
//   When it is undefined, regs_out comes purely from flops.
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     synchronous active-high reset
//   wr_en     write enable
//   wr_reg    destination register index (5 bits)
//   wr_data   write data
//   regs_out  packed array of all register values (read-mux data input)
//   written   bit i set once register i has been written since reset (sticky)

module regfile_array #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [4:0]                   wr_reg,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [DEPTH-1:0][WIDTH-1:0]  regs_out,
  output logic [DEPTH-1:0]             written
);

  localparam logic [4:0] ZeroIdx = 5'(ZERO_REG);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;
  logic [DEPTH-1:0] wr_sel;

  // One-hot write decoder. It is gated by wr_en, and writes to the zero register
  // never select an entry.
  always_comb begin
    wr_sel = '0;
    if (wr_en && (wr_reg != ZeroIdx)) begin
      wr_sel[wr_reg] = 1'b1;
    end
  end

  always_comb begin
    written_d = written_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_sel[i]) begin
        mem_d[i]     = wr_data;
        written_d[i] = 1'b1;
      end
    end
    mem_d[ZERO_REG] = '0;
    if (reset) begin
      written_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    written_q <= written_d;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_out[i] = mem_q[i];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (!reset && wr_sel[i]) begin
        regs_out[i] = wr_data;
      end
`endif
    end
    // The zero register reads as zero even before the first reset.
    regs_out[ZERO_REG] = '0;
  end

  assign written = written_q;

endmodule

// File: tb/tb_regfile_array.sv
module tb_regfile_array;

  typedef struct {
    logic [31:0][63:0] regs;
    logic [31:0]       wr;
    string             tag;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [4:0]        wr_reg;
  logic [63:0]       wr_data;
  logic [31:0][63:0] regs_out;
  logic [31:0]       written;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exp_t        exp_q[$];
  logic [63:0] m_regs [32];
  logic [31:0] m_wr;

  regfile_array #(
    .WIDTH   (64),
    .DEPTH   (32),
    .ZERO_REG(31)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .regs_out(regs_out),
    .written (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each step is one clock cycle. It pushes the view the DUT must show during
  // that cycle, which is the stored state plus any bypass. It then updates the
  // reference state at the closing edge.
  task automatic step(input logic r, input logic e, input logic [4:0] a,
                      input logic [63:0] d, input string tag);
    exp_t x;
    reset   = r;
    wr_en   = e;
    wr_reg  = a;
    wr_data = d;
    for (int i = 0; i < 32; i++) x.regs[i] = m_regs[i];
    x.wr  = m_wr;
    x.tag = tag;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!r && e && a != 5'd31) x.regs[a] = d;
`endif
    exp_q.push_back(x);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_wr = 32'd0;
    end else if (e && a != 5'd31) begin
      m_regs[a] = d;
      m_wr[a]   = 1'b1;
    end
    #1;
  endtask

  // Monitor: compares the DUT output against the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if (written !== x.wr) begin
        errors++;
        $display("FAIL %s written: got %h want %h", x.tag, written, x.wr);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (regs_out[i] !== x.regs[i]) begin
          errors++;
          $display("FAIL %s regs_out[%0d]: got %h want %h", x.tag, i, regs_out[i], x.regs[i]);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_reg  = 5'd0;
    wr_data = 64'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_wr = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    step(1'b0, 1'b0, 5'd0, 64'd0, "post_reset");

    // Scattered writes, then a two-cycle reset.
    step(1'b0, 1'b1, 5'd2,  64'h1111, "rnd_w2");
    step(1'b0, 1'b1, 5'd17, 64'h2222_3333_4444_5555, "rnd_w17");
    step(1'b0, 1'b1, 5'd30, 64'h8000_0000_0000_0001, "rnd_w30");
    step(1'b0, 1'b0, 5'd0,  64'd0, "rnd_hold");
    step(1'b1, 1'b0, 5'd0,  64'd0, "reset_c1");
    step(1'b1, 1'b0, 5'd0,  64'd0, "reset_c2");
    step(1'b0, 1'b0, 5'd0,  64'd0, "reset_clear");

    // Fill: entry i receives 155+i. The write to 31 is dropped.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 5'(i), 64'(155 + i), "fill");
    end
    step(1'b0, 1'b0, 5'd0, 64'd0, "fill_done");

    // Zero register.
    step(1'b0, 1'b1, 5'd31, 64'hDEAD_BEEF_0000_0001, "xzr_write");
    step(1'b0, 1'b0, 5'd0,  64'd0, "xzr_after");

    // Write gating, then last-write-wins on back-to-back writes.
    step(1'b0, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, "gate_ones");
    step(1'b0, 1'b0, 5'd5, 64'hx, "gate_x");
    step(1'b0, 1'b1, 5'd5, 64'd7, "b2b_7");
    step(1'b0, 1'b1, 5'd5, 64'd9, "b2b_9");
    step(1'b0, 1'b0, 5'd0, 64'd0, "b2b_after");

    // Rewrite keeps written sticky.
    step(1'b0, 1'b1, 5'd0, 64'h0123_4567_89AB_CDEF, "rewrite0");
    step(1'b0, 1'b0, 5'd0, 64'd0, "rewrite_after");

    // Reset beats a same-cycle write.
    step(1'b1, 1'b1, 5'd3, 64'h1234, "rst_prio");
    step(1'b0, 1'b0, 5'd0, 64'd0, "rst_prio_after");

    // Bypass visibility, or the absence of it, during the write cycle.
    step(1'b0, 1'b1, 5'd10, 64'hABCD, "bypass_w10");
    step(1'b0, 1'b0, 5'd0,  64'd0, "bypass_after");

    // A bypass write followed by a read of a different register.
    step(1'b0, 1'b1, 5'd11, 64'h5555_AAAA, "w11");
    step(1'b0, 1'b1, 5'd31, 64'hFFFF, "w31_bypass");
    step(1'b0, 1'b0, 5'd0,  64'd0, "final");

    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count: got %0d want >=12", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_array.md
Name: regfile_array

Overview:
- 32-entry x 64-bit register storage array for the datapath.
- Sits directly upstream of the 64-bit 32:1 read-port muxes and drives their packed data input with all 32 register values every cycle.
- Single write port, synchronous write. Entry 31 is hardwired zero (XZR).
- Also exports a per-entry "written since reset" mask for debug and scoreboard checks.

Parameters:
- WIDTH, 64, data width of each register
- DEPTH, 32, number of registers; fixed at 32 because the 5-bit select of the downstream mux requires it
- ZERO_REG, 31, index of the hardwired-zero register

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write enable for the current cycle
- wr_reg  input  5  destination register index
- wr_data  input  WIDTH  write data
- regs_out  output  [DEPTH-1:0][WIDTH-1:0]  packed array of all register values; feeds the read-mux data input
- written  output  DEPTH  bit i set once register i has been written since reset

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset.
- Reset:
  - On a clk edge with reset=1, all 32 registers are cleared to 0 and written is cleared to 0.
  - Reset takes priority over any write in the same cycle.
  - A write presented during reset is discarded.
- Write:
  - On a clk edge with reset=0, wr_en=1 and wr_reg!=ZERO_REG, register[wr_reg] <= wr_data and written[wr_reg] <= 1.
  - All other entries hold their value.
- Zero register:
  - regs_out[ZERO_REG] is constant 0.
  - A write to ZERO_REG is accepted on the port but has no effect; written[ZERO_REG] stays 0.
- Latency: a write in cycle N is visible on regs_out after the edge closing cycle N, i.e. from cycle N+1. Without the optional feature there is no same-cycle visibility.
- Consecutive writes to the same register apply in order, last write wins. Writes are back-to-back capable, one per cycle.
- wr_en=0: no state change, regardless of wr_reg and wr_data (including X values).
- written is sticky until reset; a rewrite leaves the bit at 1.
- No state machine beyond the storage. Internally: a 5-to-32 one-hot write decoder gated by wr_en, then 32 enabled 64-bit registers.
- Outputs are driven directly from flops (or constant zero), with no combinational path from inputs to outputs, except as described under the optional feature.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When wr_en=1, reset=0 and wr_reg!=ZERO_REG, regs_out[wr_reg] shows wr_data combinationally in the same cycle.
  - All other entries show stored values.
  - Lets a same-cycle read through the downstream mux see the new value.
  - written is unaffected; it still updates at the edge.
- Undefined: regs_out is purely registered, as described under Behaviour.

Test Plan:
- Reset: assert reset for 2 cycles after random writes -> all regs_out entries 0 and written=0 on the following cycle.
- Fill: write 155+i to register i for i=0..31, one per cycle, then deassert wr_en -> regs_out[i]=155+i for i=0..30, regs_out[31]=0, written=32'h7FFF_FFFF. Walking the downstream mux select 0..31 returns the same values.
- Zero register: write 64'hDEAD_BEEF_0000_0001 to register 31 -> regs_out[31] stays 0, written[31]=0, all other entries unchanged.
- Write gating: wr_en=0 with wr_reg=5 and wr_data=64'hFFFF_FFFF_FFFF_FFFF -> register 5 keeps its prior value. Then write 7 then 9 to register 5 on consecutive cycles -> regs_out[5]=7, then 9.
- Reset priority: reset=1 together with wr_en=1, wr_reg=3, wr_data=64'h1234 -> regs_out[3]=0 and written[3]=0 afterwards.
- Bypass (only with REGFILE_WRITE_BYPASS_EN): wr_en=1, wr_reg=10, wr_data=64'hABCD -> regs_out[10]=64'hABCD before the edge. Without the macro, the old value is shown until the edge.
